// File: rtl/colide_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | colide_scan: per-frame scan of an obstacle segment table, reporting      |
// | contact on all four sides of the square object.      Revision: 1.0       |
// +--------------------------------------------------------------------------+
module colide_scan #(
  parameter int N_OBST = 10,
  parameter int X_W    = 10,
  parameter int Y_W    = 9,
  parameter int T_W    = 7,
  parameter int MARGIN = 1
) (
  input  logic                      VGA_clk,
  input  logic                      reset,
  input  logic                      wr_en,
  input  logic [$clog2(N_OBST)-1:0] wr_addr,
  input  logic                      wr_valid,
  input  logic                      wr_vert,
  input  logic [X_W-1:0]            wr_pos,
  input  logic [X_W-1:0]            wr_ini,
  input  logic [X_W-1:0]            wr_fin,
  input  logic                      start,
  input  logic [X_W-1:0]            xPos,
  input  logic [Y_W-1:0]            yPos,
  input  logic [T_W-1:0]            tamanho,
  output logic                      busy,
  output logic                      done,
  output logic                      colisao_min_y,
  output logic                      colisao_max_y,
  output logic                      colisao_min_x,
  output logic                      colisao_max_x
);

  localparam int A_W = $clog2(N_OBST);
  localparam int C_W = X_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [A_W-1:0] idx_q, idx_d;
  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic [T_W-1:0] t_q, t_d;
  logic [3:0]     acc_q, acc_d;
  logic [3:0]     flags_q, flags_d;
  logic           done_q, done_d;

  logic [N_OBST-1:0] valid_q, valid_d;
  logic [N_OBST-1:0] vert_q, vert_d;
  logic [X_W-1:0]    pos_q [N_OBST];
  logic [X_W-1:0]    pos_d [N_OBST];
  logic [X_W-1:0]    ini_q [N_OBST];
  logic [X_W-1:0]    ini_d [N_OBST];
  logic [X_W-1:0]    fin_q [N_OBST];
  logic [X_W-1:0]    fin_d [N_OBST];

  // All compares are one bit wider than the coordinates so R/B never wrap.
  logic [C_W-1:0] x_e, y_e, r_e, b_e, r_m, b_m;
  logic [C_W-1:0] pos_e, ini_e, fin_e, pos_m;
  logic           live, is_vert, ovx, ovy;
  logic [3:0]     hit;

  always_comb begin
    valid_d = valid_q;
    vert_d  = vert_q;
    pos_d   = pos_q;
    ini_d   = ini_q;
    fin_d   = fin_q;
    if (wr_en && (int'(wr_addr) < N_OBST)) begin
      valid_d[wr_addr] = wr_valid;
      vert_d[wr_addr]  = wr_vert;
      pos_d[wr_addr]   = wr_pos;
      ini_d[wr_addr]   = wr_ini;
      fin_d[wr_addr]   = wr_fin;
    end
  end

  always_comb begin
    x_e     = C_W'(x_q);
    y_e     = C_W'(y_q);
    r_e     = x_e + C_W'(t_q);
    b_e     = y_e + C_W'(t_q);
    r_m     = r_e + C_W'(MARGIN);
    b_m     = b_e + C_W'(MARGIN);
    pos_e   = C_W'(pos_q[idx_q]);
    ini_e   = C_W'(ini_q[idx_q]);
    fin_e   = C_W'(fin_q[idx_q]);
    pos_m   = pos_e + C_W'(MARGIN);
    live    = valid_q[idx_q] && (ini_e < fin_e);
    is_vert = vert_q[idx_q];
    ovx     = (r_e > ini_e) && (x_e < fin_e);
    ovy     = (b_e > ini_e) && (y_e < fin_e);
    hit[3]  = live && !is_vert && ovx && (pos_e < y_e) && (y_e <= pos_m);
    hit[2]  = live && !is_vert && ovx && (b_e <= pos_e) && (pos_e < b_m);
    hit[1]  = live && is_vert && ovy && (pos_e < x_e) && (x_e <= pos_m);
    hit[0]  = live && is_vert && ovy && (r_e <= pos_e) && (pos_e < r_m);
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    x_d     = x_q;
    y_d     = y_q;
    t_d     = t_q;
    acc_d   = acc_q;
    flags_d = flags_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SCAN;
          x_d     = xPos;
          y_d     = yPos;
          t_d     = tamanho;
          idx_d   = '0;
          acc_d   = '0;
        end
      end
      ST_SCAN: begin
        acc_d = acc_q | hit;
        if (idx_q == A_W'(N_OBST - 1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + A_W'(1);
        end
      end
      ST_DONE: begin
        flags_d = acc_q;
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(negedge VGA_clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      t_q     <= '0;
      acc_q   <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
      valid_q <= '0;
      vert_q  <= '0;
      pos_q   <= '{default: '0};
      ini_q   <= '{default: '0};
      fin_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      x_q     <= x_d;
      y_q     <= y_d;
      t_q     <= t_d;
      acc_q   <= acc_d;
      flags_q <= flags_d;
      done_q  <= done_d;
      valid_q <= valid_d;
      vert_q  <= vert_d;
      pos_q   <= pos_d;
      ini_q   <= ini_d;
      fin_q   <= fin_d;
    end
  end

  assign busy          = (state_q != ST_IDLE);
  assign done          = done_q;
  assign colisao_min_y = flags_q[3];
  assign colisao_max_y = flags_q[2];
  assign colisao_min_x = flags_q[1];
  assign colisao_max_x = flags_q[0];

endmodule
`default_nettype wire

// File: tb/tb_colide_scan.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_colide_scan: bench for colide_scan.               Revision: 1.0       |
// +--------------------------------------------------------------------------+
module tb_colide_scan;

  localparam int N  = 10;
  localparam int XW = 10;
  localparam int YW = 9;
  localparam int TW = 7;
  localparam int MG = 1;
  localparam int AW = $clog2(N);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic          wr_valid = 1'b0;
  logic          wr_vert = 1'b0;
  logic [XW-1:0] wr_pos = '0;
  logic [XW-1:0] wr_ini = '0;
  logic [XW-1:0] wr_fin = '0;
  logic          start = 1'b0;
  logic [XW-1:0] xPos = '0;
  logic [YW-1:0] yPos = '0;
  logic [TW-1:0] tamanho = '0;
  logic          busy, done, c_min_y, c_max_y, c_min_x, c_max_x;

  int n_tests = 0;
  int n_fail  = 0;

  bit m_valid [N];
  bit m_vert  [N];
  int m_pos   [N];
  int m_ini   [N];
  int m_fin   [N];

  typedef struct {
    bit         v;
    bit         vt;
    int         pos, ini, fin, x, y, t;
    logic [3:0] exp;
  } vec_t;
  vec_t vecs [8];

  always #5 clk = ~clk;

  colide_scan #(.N_OBST(N), .X_W(XW), .Y_W(YW), .T_W(TW), .MARGIN(MG)) dut (
    .VGA_clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_valid(wr_valid), .wr_vert(wr_vert), .wr_pos(wr_pos), .wr_ini(wr_ini),
    .wr_fin(wr_fin), .start(start), .xPos(xPos), .yPos(yPos), .tamanho(tamanho),
    .busy(busy), .done(done), .colisao_min_y(c_min_y), .colisao_max_y(c_max_y),
    .colisao_min_x(c_min_x), .colisao_max_x(c_max_x)
  );

  function automatic logic [31:0] flags();
    return 32'({c_min_y, c_max_y, c_min_x, c_max_x});
  endfunction

  // Reference: direct reading of the contact rules over the whole table.
  function automatic logic [31:0] model(int x, int y, int t);
    logic [3:0] f = '0;
    int r = x + t;
    int b = y + t;
    for (int i = 0; i < N; i++) begin
      if (m_valid[i] && m_ini[i] < m_fin[i]) begin
        if (!m_vert[i]) begin
          if (r > m_ini[i] && x < m_fin[i]) begin
            if (m_pos[i] < y && y <= m_pos[i] + MG) f[3] = 1'b1;
            if (b <= m_pos[i] && m_pos[i] < b + MG) f[2] = 1'b1;
          end
        end else begin
          if (b > m_ini[i] && y < m_fin[i]) begin
            if (m_pos[i] < x && x <= m_pos[i] + MG) f[1] = 1'b1;
            if (r <= m_pos[i] && m_pos[i] < r + MG) f[0] = 1'b1;
          end
        end
      end
    end
    return 32'(f);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic m_write(int addr, bit v, bit vt, int p, int i, int f);
    if (addr < N) begin
      m_valid[addr] = v; m_vert[addr] = vt;
      m_pos[addr] = p; m_ini[addr] = i; m_fin[addr] = f;
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < N; i++) m_write(i, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic set_wr(int addr, bit v, bit vt, int p, int i, int f);
    wr_en = 1'b1; wr_addr = AW'(addr); wr_valid = v; wr_vert = vt;
    wr_pos = XW'(p); wr_ini = XW'(i); wr_fin = XW'(f);
  endtask

  task automatic write_entry(int addr, bit v, bit vt, int p, int i, int f);
    set_wr(addr, v, vt, p, i, f);
    m_write(addr, v, vt, p, i, f);
    @(posedge clk);
    wr_en = 1'b0;
  endtask

  // Pulses start, scrambles the position mid-scan, waits (bounded) for done.
  task automatic run_scan(int x, int y, int t, output int lat, output int nb);
    xPos = XW'(x); yPos = YW'(y); tamanho = TW'(t); start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    xPos = XW'($urandom); yPos = YW'($urandom); tamanho = TW'($urandom);
    lat = 1; nb = 0;
    while (!done && lat < 200) begin
      if (busy) nb++;
      @(posedge clk);
      lat++;
    end
  endtask

  task automatic no_done_for(string name, int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      if (done || busy) seen++;
    end
    check(name, 32'(seen), 32'd0);
  endtask

  initial begin
    int lat, nb, cyc;
    logic [31:0] exp_mid;

    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nb, cyc;
    logic [31:0] exp_mid;

    vecs[0] = '{1, 0, 110, 100, 350, 200, 111, 20, 4'b1000};
    vecs[1] = '{1, 0, 110, 100, 350, 200, 112, 20, 4'b0000};
    vecs[2] = '{1, 0, 110, 100, 350, 350, 111, 20, 4'b0000};
    vecs[3] = '{1, 0, 280, 340, 590, 400, 260, 20, 4'b0100};
    vecs[4] = '{1, 1, 100,   0, 480, 101,  50, 10, 4'b0010};
    vecs[5] = '{1, 1, 600,   0, 480, 590,  50, 10, 4'b0001};
    vecs[6] = '{1, 0, 110, 350, 100, 200, 111, 20, 4'b0000};
    vecs[7] = '{0, 0, 110, 100, 350, 200, 111, 20, 4'b0000};
    m_clear();

    repeat (3) @(posedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_flags", flags(), 0);
    reset = 1'b0;
    @(posedge clk);

    run_scan(300, 200, 30, lat, nb);
    check("empty_latency", 32'(lat), 32'(N + 2));
    check("empty_busy_len", 32'(nb), 32'(N + 1));
    check("empty_flags", flags(), 0);

    for (int k = 0; k < 8; k++) begin
      write_entry(0, vecs[k].v, vecs[k].vt, vecs[k].pos, vecs[k].ini, vecs[k].fin);
      run_scan(vecs[k].x, vecs[k].y, vecs[k].t, lat, nb);
      check($sformatf("vec%0d_latency", k), 32'(lat), 32'(N + 2));
      check($sformatf("vec%0d_flags", k), flags(), 32'(vecs[k].exp));
    end

    write_entry(0, 1'b0, 1'b0, 0, 0, 0);
    write_entry(12, 1'b1, 1'b0, 110, 100, 350);
    run_scan(200, 111, 20, lat, nb);
    check("oob_write_flags", flags(), 0);

    for (int it = 0; it < 25; it++) begin
      int x = $urandom_range(0, 900);
      int y = $urandom_range(0, 400);
      int t = $urandom_range(1, 127);
      for (int e = 0; e < N; e++) begin
        bit vt = 1'($urandom_range(0, 1));
        int base = vt ? (($urandom_range(0, 1) != 0) ? x : x + t)
                      : (($urandom_range(0, 1) != 0) ? y : y + t);
        int p  = base + $urandom_range(0, 4) - 2;
        int i0 = $urandom_range(0, 600);
        int f0 = i0 + $urandom_range(0, 500) - 50;
        if (p < 0) p = 0;
        if (p > 1023) p = 1023;
        if (f0 < 0) f0 = 0;
        if (f0 > 1023) f0 = 1023;
        write_entry(e, ($urandom_range(0, 3) != 0), vt, p, i0, f0);
      end
      run_scan(x, y, t, lat, nb);
      check($sformatf("rand%0d_flags", it), flags(), model(x, y, t));
    end

    // Mid-scan table writes and an ignored start.
    for (int e = 0; e < N; e++) write_entry(e, 1'b0, 1'b0, 0, 0, 0);
    m_write(N - 1, 1'b1, 1'b0, 110, 100, 350);
    exp_mid = model(200, 111, 20);
    m_write(0, 1'b1, 1'b1, 220, 0, 480);
    xPos = 10'd200; yPos = 9'd111; tamanho = 7'd20; start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 200) begin
      wr_en = 1'b0; start = 1'b0;
      if (cyc == 3) set_wr(N - 1, 1'b1, 1'b0, 110, 100, 350);
      if (cyc == 4) set_wr(0, 1'b1, 1'b1, 220, 0, 480);
      if (cyc == 5) start = 1'b1;
      @(posedge clk);
      cyc++;
    end
    wr_en = 1'b0; start = 1'b0;
    check("mid_latency", 32'(cyc), 32'(N + 2));
    check("mid_flags", flags(), exp_mid);
    check("mid_flags_const", flags(), 32'h8);
    no_done_for("start_while_busy", N + 3);
    check("flags_hold", flags(), 32'h8);
    run_scan(200, 111, 20, lat, nb);
    check("next_scan_flags", flags(), model(200, 111, 20));
    check("next_scan_const", flags(), 32'h9);

    // Reset while scanning at idx 5.
    xPos = 10'd200; yPos = 9'd111; tamanho = 7'd20; start = 1'b1;
    @(posedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_done", 32'(done), 0);
    check("abort_flags", flags(), 0);
    m_clear();
    @(posedge clk);
    reset = 1'b0;
    no_done_for("abort_no_done", N + 3);

    write_entry(0, 1'b1, 1'b0, 127, 0, 1023);
    write_entry(1, 1'b1, 1'b1, 1022, 0, 480);
    run_scan(1023, 0, 127, lat, nb);
    check("edge_latency", 32'(lat), 32'(N + 2));
    check("edge_busy_len", 32'(nb), 32'(N + 1));
    check("edge_flags", flags(), 32'h2);
    check("edge_model", flags(), model(1023, 0, 127));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
